// File: rtl/sm_loader.sv
// Host-side loader/sequencer for the SM core: streams code and data RAM images in, holds the core in INIT, then collects its result.
// Optional watchdog on the core's ready pulse is built when SM_LOADER_TIMEOUT_EN is defined.
module sm_loader #(
  parameter int CODERAM_ADDR_WIDTH = 6,
  parameter int CODERAM_DATA_WIDTH = 21,
  parameter int DATARAM_ADDR_WIDTH = 6,
  parameter int DATARAM_DATA_WIDTH = 16,
  parameter int RESULT_WIDTH       = 16,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                          i_CLK,
  input  logic                          i_RSTn,
  input  logic                          i_IN_VALID,
  output logic                          o_IN_READY,
  input  logic [CODERAM_DATA_WIDTH-1:0] i_IN_DATA,
  output logic                          o_CODERAM_WE,
  output logic [CODERAM_ADDR_WIDTH-1:0] o_CODERAM_ADDR,
  output logic [CODERAM_DATA_WIDTH-1:0] o_CODERAM_DATA,
  output logic                          o_DATARAM_WE,
  output logic [DATARAM_ADDR_WIDTH-1:0] o_DATARAM_ADDR,
  output logic [DATARAM_DATA_WIDTH-1:0] o_DATARAM_DATA,
  output logic                          o_TB_WE,
  input  logic                          i_RDY,
  input  logic                          i_ERROR,
  input  logic [RESULT_WIDTH-1:0]       i_RESULT,
  output logic                          o_OUT_VALID,
  input  logic                          i_OUT_READY,
  output logic [RESULT_WIDTH-1:0]       o_OUT_RESULT,
  output logic                          o_OUT_ERROR,
  output logic                          o_OUT_TIMEOUT,
  output logic                          o_BUSY,
  output logic [2:0]                    dbg_state
);

  // Handshakes: a beat (input) or report (output) transfers on the rising edge where
  // valid and ready are both high; the sender holds valid and payload stable until then.

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_CODE = 3'd1,
    LOAD_DATA = 3'd2,
    FLUSH     = 3'd3,
    WAIT_RDY  = 3'd4,
    REPORT    = 3'd5
  } state_t;

  state_t state, next_state;

  logic [CODERAM_ADDR_WIDTH-1:0] last_code, code_cnt;
  logic [DATARAM_ADDR_WIDTH-1:0] last_data, data_cnt;
  logic                          accept;
  logic                          timeout_hit;

  // Ready is held low while reset is asserted so every output reads 0 in reset.
  assign o_IN_READY = i_RSTn &&
                      ((state == IDLE) || (state == LOAD_CODE) || (state == LOAD_DATA));
  assign accept     = i_IN_VALID && o_IN_READY;
  assign o_BUSY     = (state != IDLE);
  assign dbg_state  = state;

`ifdef SM_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_cnt;

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      wait_cnt <= '0;
    end else if (state != WAIT_RDY) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + TW'(1);
    end
  end

  assign timeout_hit = (state == WAIT_RDY) && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      o_OUT_TIMEOUT <= 1'b0;
    end else if (state == IDLE && accept) begin
      o_OUT_TIMEOUT <= 1'b0;
    end else if (timeout_hit && !i_RDY) begin
      o_OUT_TIMEOUT <= 1'b1;
    end
  end
`else
  assign timeout_hit   = 1'b0;
  assign o_OUT_TIMEOUT = 1'b0;
`endif

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (accept) next_state = LOAD_CODE;
      LOAD_CODE: if (accept && code_cnt == last_code) next_state = LOAD_DATA;
      LOAD_DATA: if (accept && data_cnt == last_data) next_state = FLUSH;
      FLUSH:     next_state = WAIT_RDY;
      WAIT_RDY:  if (i_RDY || timeout_hit) next_state = REPORT;
      REPORT:    if (i_OUT_READY) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      last_code      <= '0;
      last_data      <= '0;
      code_cnt       <= '0;
      data_cnt       <= '0;
      o_CODERAM_WE   <= 1'b0;
      o_CODERAM_ADDR <= '0;
      o_CODERAM_DATA <= '0;
      o_DATARAM_WE   <= 1'b0;
      o_DATARAM_ADDR <= '0;
      o_DATARAM_DATA <= '0;
      o_TB_WE        <= 1'b0;
      o_OUT_VALID    <= 1'b0;
      o_OUT_RESULT   <= '0;
      o_OUT_ERROR    <= 1'b0;
    end else begin
      o_CODERAM_WE <= 1'b0;
      o_DATARAM_WE <= 1'b0;
      // Core stays in INIT from the cycle after the header until WAIT_RDY is entered.
      o_TB_WE      <= (next_state == LOAD_CODE) || (next_state == LOAD_DATA) ||
                      (next_state == FLUSH);
      o_OUT_VALID  <= (next_state == REPORT);
      case (state)
        IDLE: begin
          if (accept) begin
            last_code <= i_IN_DATA[CODERAM_ADDR_WIDTH-1:0];
            last_data <= i_IN_DATA[CODERAM_ADDR_WIDTH +: DATARAM_ADDR_WIDTH];
            code_cnt  <= '0;
            data_cnt  <= '0;
          end
        end
        LOAD_CODE: begin
          if (accept) begin
            o_CODERAM_WE   <= 1'b1;
            o_CODERAM_ADDR <= code_cnt;
            o_CODERAM_DATA <= i_IN_DATA;
            code_cnt       <= code_cnt + CODERAM_ADDR_WIDTH'(1);
          end
        end
        LOAD_DATA: begin
          if (accept) begin
            o_DATARAM_WE   <= 1'b1;
            o_DATARAM_ADDR <= data_cnt;
            o_DATARAM_DATA <= i_IN_DATA[DATARAM_DATA_WIDTH-1:0];
            data_cnt       <= data_cnt + DATARAM_ADDR_WIDTH'(1);
          end
        end
        WAIT_RDY: begin
          if (i_RDY) begin
            o_OUT_RESULT <= i_RESULT;
            o_OUT_ERROR  <= i_ERROR;
          end else if (timeout_hit) begin
            o_OUT_RESULT <= '0;
            o_OUT_ERROR  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
